// File: rtl/gshare_dual_predictor_p.sv
// rtl/gshare_dual_predictor_p.sv - two-lane gshare direction predictor with init sweep and statistics
// One shared pattern table predicts both fetch slots; history is shifted speculatively and repaired on mispredict.
module gshare_dual_predictor_p #(
    parameter int PC_W     = 8,
    parameter int IDX_W    = 8,
    parameter int GHR_W    = 8,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              br_f_1,
    input  logic              br_f_2,
    input  logic [PC_W-1:0]   pc_f_1,
    input  logic [PC_W-1:0]   pc_f_2,
    output logic              prediction_1,
    output logic              prediction_2,
    output logic [GHR_W-1:0]  ghr_f_1,
    output logic [GHR_W-1:0]  ghr_f_2,
    input  logic              br_e_1,
    input  logic              br_e_2,
    input  logic [PC_W-1:0]   pc_e_1,
    input  logic [PC_W-1:0]   pc_e_2,
    input  logic [GHR_W-1:0]  ghr_e_1,
    input  logic [GHR_W-1:0]  ghr_e_2,
    input  logic              taken_e_1,
    input  logic              taken_e_2,
    input  logic              mispred_e_1,
    input  logic              mispred_e_2,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispreds
);

    localparam int DEPTH = 2**IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [GHR_W-1:0]   ghr;
    logic [CNT_W-1:0]   pht [DEPTH];

    logic [IDX_W-1:0]   idx_f_1, idx_f_2, idx_e_1, idx_e_2;
    logic [GHR_W-1:0]   ghr_spec;
    logic [CNT_W-1:0]   upd_1, base_2, upd_2;
    logic               mp_1, mp_2;
    logic [1:0]         look_inc, misp_inc;

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic t);
        if (t)
            return (&c) ? c : c + CNT_W'(1);
        else
            return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] s, input logic [1:0] inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, s} + (STAT_W+1)'(inc);
        return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
    endfunction

    always_comb begin
        ghr_f_1      = ghr;
        idx_f_1      = IDX_W'(pc_f_1) ^ IDX_W'(ghr);
        prediction_1 = ready & pht[idx_f_1][CNT_W-1];
        ghr_f_2      = br_f_1 ? {ghr[GHR_W-2:0], prediction_1} : ghr;
        idx_f_2      = IDX_W'(pc_f_2) ^ IDX_W'(ghr_f_2);
        prediction_2 = ready & pht[idx_f_2][CNT_W-1];
        ghr_spec     = br_f_2 ? {ghr_f_2[GHR_W-2:0], prediction_2} : ghr_f_2;
    end

    // When both lanes hit the same entry, lane 2 trains on lane 1's result so one write carries both steps.
    always_comb begin
        idx_e_1  = IDX_W'(pc_e_1) ^ IDX_W'(ghr_e_1);
        idx_e_2  = IDX_W'(pc_e_2) ^ IDX_W'(ghr_e_2);
        upd_1    = sat_step(pht[idx_e_1], taken_e_1);
        base_2   = (br_e_1 && (idx_e_1 == idx_e_2)) ? upd_1 : pht[idx_e_2];
        upd_2    = sat_step(base_2, taken_e_2);
        mp_1     = br_e_1 & mispred_e_1;
        mp_2     = br_e_2 & mispred_e_2;
        look_inc = {1'b0, br_f_1} + {1'b0, br_f_2};
        misp_inc = {1'b0, mp_1} + {1'b0, mp_2};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT) begin
                pht[ptr] <= CNT_W'(CNT_INIT);
            end else begin
                if (br_e_1)
                    pht[idx_e_1] <= upd_1;
                if (br_e_2)
                    pht[idx_e_2] <= upd_2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= INIT;
            ptr           <= '0;
            ghr           <= '0;
            ready         <= 1'b0;
            stat_lookups  <= '0;
            stat_mispreds <= '0;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + IDX_W'(1);
                    if (&ptr) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // An older-lane repair also squashes the younger lane's repair and the fetch shift.
                    if (mp_1)
                        ghr <= {ghr_e_1[GHR_W-2:0], taken_e_1};
                    else if (mp_2)
                        ghr <= {ghr_e_2[GHR_W-2:0], taken_e_2};
                    else
                        ghr <= ghr_spec;
                    stat_lookups  <= sat_add(stat_lookups, look_inc);
                    stat_mispreds <= sat_add(stat_mispreds, misp_inc);
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_dual_predictor_p.sv
// tb/tb_gshare_dual_predictor_p.sv - directed scoreboard bench for gshare_dual_predictor_p
module tb_gshare_dual_predictor_p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ready;
    logic        br_f_1, br_f_2;
    logic [7:0]  pc_f_1, pc_f_2;
    logic        prediction_1, prediction_2;
    logic [7:0]  ghr_f_1, ghr_f_2;
    logic        br_e_1, br_e_2;
    logic [7:0]  pc_e_1, pc_e_2;
    logic [7:0]  ghr_e_1, ghr_e_2;
    logic        taken_e_1, taken_e_2;
    logic        mispred_e_1, mispred_e_2;
    logic [15:0] stat_lookups, stat_mispreds;

    gshare_dual_predictor_p dut (
        .clk(clk), .reset(reset), .ready(ready),
        .br_f_1(br_f_1), .br_f_2(br_f_2), .pc_f_1(pc_f_1), .pc_f_2(pc_f_2),
        .prediction_1(prediction_1), .prediction_2(prediction_2),
        .ghr_f_1(ghr_f_1), .ghr_f_2(ghr_f_2),
        .br_e_1(br_e_1), .br_e_2(br_e_2), .pc_e_1(pc_e_1), .pc_e_2(pc_e_2),
        .ghr_e_1(ghr_e_1), .ghr_e_2(ghr_e_2),
        .taken_e_1(taken_e_1), .taken_e_2(taken_e_2),
        .mispred_e_1(mispred_e_1), .mispred_e_2(mispred_e_2),
        .stat_lookups(stat_lookups), .stat_mispreds(stat_mispreds)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          m_look = 0;
    int          m_misp = 0;
    bit          m_run = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic clear_inputs();
        br_f_1 = 0; br_f_2 = 0; pc_f_1 = 0; pc_f_2 = 0;
        br_e_1 = 0; br_e_2 = 0; pc_e_1 = 0; pc_e_2 = 0;
        ghr_e_1 = 0; ghr_e_2 = 0; taken_e_1 = 0; taken_e_2 = 0;
        mispred_e_1 = 0; mispred_e_2 = 0;
    endtask

    task automatic tick();
        if (m_run) begin
            m_look = m_look + int'(br_f_1) + int'(br_f_2);
            if (m_look > 65535) m_look = 65535;
            m_misp = m_misp + int'(br_e_1 & mispred_e_1) + int'(br_e_2 & mispred_e_2);
            if (m_misp > 65535) m_misp = 65535;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic train1(input logic [7:0] pc, input logic tk);
        clear_inputs();
        br_e_1 = 1; pc_e_1 = pc; ghr_e_1 = 8'h00; taken_e_1 = tk;
        tick();
        clear_inputs();
    endtask

    task automatic train2(input logic [7:0] pc, input logic t1, input logic t2);
        clear_inputs();
        br_e_1 = 1; pc_e_1 = pc; taken_e_1 = t1;
        br_e_2 = 1; pc_e_2 = pc; taken_e_2 = t2;
        tick();
        clear_inputs();
    endtask

    task automatic probe(input string tag, input logic [7:0] pc, input logic exp_bit);
        pc_f_1 = pc;
        #1;
        push(tag, 32'(exp_bit));
        check(32'(prediction_1));
    endtask

    task automatic recover1(input logic [7:0] g, input logic tk);
        clear_inputs();
        br_e_1 = 1; mispred_e_1 = 1; ghr_e_1 = g; taken_e_1 = tk;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        repeat (3) tick();
        push("rst_ready", 0);     check(32'(ready));
        push("rst_lookups", 0);   check(32'(stat_lookups));
        push("rst_mispreds", 0);  check(32'(stat_mispreds));
        push("rst_ghr", 0);       check(32'(ghr_f_1));

        reset = 1;
        repeat (100) tick();
        push("sweep_100_ready", 0); check(32'(ready));
        reset = 0;
        tick();
        reset = 1;
        repeat (255) tick();
        push("sweep_255_ready", 0); check(32'(ready));
        tick();
        push("sweep_256_ready", 1); check(32'(ready));
        m_run = 1;

        for (int i = 0; i < 6; i++) begin
            pc_f_1 = 8'($urandom);
            pc_f_2 = 8'($urandom);
            #1;
            push("init_probe_1", 0); check(32'(prediction_1));
            push("init_probe_2", 0); check(32'(prediction_2));
        end
        clear_inputs();

        train1(8'h10, 1);
        train1(8'h10, 1);
        probe("train_10_cnt3", 8'h10, 1);
        pc_f_2 = 8'h10;
        #1;
        push("train_10_slot2", 1); check(32'(prediction_2));
        train1(8'h10, 1);
        train1(8'h10, 1);
        train1(8'h10, 0);
        probe("sat_hi_cnt2", 8'h10, 1);
        train1(8'h10, 0);
        probe("sat_hi_cnt1", 8'h10, 0);

        train1(8'h20, 1);
        train1(8'h20, 1);
        train2(8'h20, 1, 0);
        probe("dual_20_cnt2", 8'h20, 1);
        train1(8'h20, 0);
        probe("dual_20_cnt1", 8'h20, 0);

        train1(8'h30, 0);
        train2(8'h30, 1, 0);
        train1(8'h30, 1);
        probe("dual_30_cnt1", 8'h30, 0);

        train1(8'h40, 0);
        train2(8'h40, 0, 1);
        train1(8'h40, 1);
        probe("dual_40_cnt2", 8'h40, 1);

        recover1(8'h52, 1);
        push("recover_a5", 8'hA5); check(32'(ghr_f_1));
        br_f_1 = 1; pc_f_1 = 8'hE5;
        br_f_2 = 1; pc_f_2 = 8'h0B;
        #1;
        push("dual_fetch_p1", 1);     check(32'(prediction_1));
        push("dual_fetch_p2", 1);     check(32'(prediction_2));
        push("dual_fetch_ghr2", 8'h4B); check(32'(ghr_f_2));
        tick();
        clear_inputs();
        push("spec_shift_ghr", 8'h97); check(32'(ghr_f_1));

        recover1(8'h52, 1);
        br_f_1 = 1; pc_f_1 = 8'hE5;
        br_f_2 = 1; pc_f_2 = 8'h0B;
        br_e_1 = 1; mispred_e_1 = 1; ghr_e_1 = 8'h3C; taken_e_1 = 0;
        br_e_2 = 1; mispred_e_2 = 1; ghr_e_2 = 8'hFF; taken_e_2 = 1;
        tick();
        clear_inputs();
        push("recover_lane1_override", 8'h78); check(32'(ghr_f_1));

        br_e_2 = 1; mispred_e_2 = 1; ghr_e_2 = 8'h0F; taken_e_2 = 1;
        tick();
        clear_inputs();
        push("recover_lane2", 8'h1F); check(32'(ghr_f_1));

        push("stat_lookups_mid", 32'(m_look));  check(32'(stat_lookups));
        push("stat_mispreds_mid", 32'(m_misp)); check(32'(stat_mispreds));

        // mispredict with br_e low must not count
        mispred_e_1 = 1; mispred_e_2 = 1;
        tick();
        clear_inputs();
        push("mispred_no_br", 32'(m_misp)); check(32'(stat_mispreds));

        br_f_1 = 1; br_f_2 = 1;
        repeat (35000) tick();
        clear_inputs();
        push("lookups_sat", 32'hFFFF);          check(32'(stat_lookups));
        push("lookups_model", 32'(m_look));     check(32'(stat_lookups));
        push("mispreds_after_sat", 32'(m_misp)); check(32'(stat_mispreds));

        reset = 0;
        m_run = 0; m_look = 0; m_misp = 0;
        tick();
        push("midrst_lookups", 0);  check(32'(stat_lookups));
        push("midrst_mispreds", 0); check(32'(stat_mispreds));
        push("midrst_ready", 0);    check(32'(ready));
        push("midrst_ghr", 0);      check(32'(ghr_f_1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
